// File: rtl/double_pulse_driver_if.sv
// Gate-drive request/response bundle for one switch leg of the double-pulse driver.
// The master side is the sequence requester; the slave side is the driver.
interface double_pulse_driver_if;
  logic enable;
  logic TEM;
  logic K1;
  logic K2;

  modport master (
    output enable,
    output TEM,
    input  K1,
    input  K2
  );

  modport slave (
    input  enable,
    input  TEM,
    output K1,
    output K2
  );
endinterface

// File: rtl/double_pulse_driver.sv
// Single-shot double-pulse gate-drive sequencer with dead-time interlock and
// over-temperature inhibit, plus a standalone interlock checker.
module double_pulse_driver #(
  parameter int unsigned ARM_CYC  = 4000,
  parameter int unsigned P1_CYC   = 400,
  parameter int unsigned GAP_CYC  = 200,
  parameter int unsigned P2_CYC   = 200,
  parameter int unsigned DEAD_CYC = 20
) (
  input  logic                  clk,
  input  logic                  rst,
  double_pulse_driver_if.slave  bus
);

  localparam logic [15:0] ARM_LAST = 16'(ARM_CYC - 32'd1);
  localparam logic [15:0] P1_LAST  = 16'(P1_CYC - 32'd1);
  localparam logic [15:0] GAP_LAST = 16'(GAP_CYC - 32'd1);
  localparam logic [15:0] P2_LAST  = 16'(P2_CYC - 32'd1);
  // K2 window inside the gap; empty when the gap cannot hold two dead times.
  localparam bit          K2_EN    = (GAP_CYC > (32'd2 * DEAD_CYC));
  localparam logic [15:0] K2_FIRST = 16'(DEAD_CYC);
  localparam logic [15:0] K2_LAST  = K2_EN ? 16'(GAP_CYC - DEAD_CYC - 32'd1) : 16'd0;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ARM    = 3'd1,
    ST_PULSE1 = 3'd2,
    ST_GAP    = 3'd3,
    ST_PULSE2 = 3'd4,
    ST_DONE   = 3'd5,
    ST_FAULT  = 3'd6
  } state_t;

  logic        tem_meta_r;
  logic        tem_sync_r;
  logic        tem_s;
  state_t      state_r;
  state_t      state_nx_s;
  logic [15:0] count_r;
  logic [15:0] count_nx_s;
  logic        k1_r;
  logic        k2_r;
  logic        k1_nx_s;
  logic        k2_nx_s;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    if (v == 16'hFFFF) begin
      return v;
    end else begin
      return v + 16'd1;
    end
  endfunction

  function automatic logic in_k2_window(input logic [15:0] v);
    if (K2_EN) begin
      return (v >= K2_FIRST) && (v <= K2_LAST);
    end else begin
      return 1'b0;
    end
  endfunction

  assign tem_s = tem_sync_r;

  // Two-flop synchroniser for the asynchronous over-temperature input.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tem_meta_r <= 1'b0;
      tem_sync_r <= 1'b0;
    end else begin
      tem_meta_r <= bus.TEM;
      tem_sync_r <= tem_meta_r;
    end
  end

  // State and phase counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
      count_r <= 16'd0;
    end else begin
      state_r <= state_nx_s;
      count_r <= count_nx_s;
    end
  end

  // Next-state logic; the fault check wraps the case so it beats every other transition.
  always_comb begin
    state_nx_s = state_r;
    count_nx_s = count_r;
    if (tem_s && (state_r != ST_FAULT)) begin
      state_nx_s = ST_FAULT;
      count_nx_s = 16'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (bus.enable) begin
            state_nx_s = ST_ARM;
            count_nx_s = 16'd0;
          end else begin
            state_nx_s = ST_IDLE;
            count_nx_s = 16'd0;
          end
        end
        ST_ARM: begin
          if (!bus.enable) begin
            state_nx_s = ST_IDLE;
            count_nx_s = 16'd0;
          end else if (count_r == ARM_LAST) begin
            state_nx_s = ST_PULSE1;
            count_nx_s = 16'd0;
          end else begin
            count_nx_s = sat_inc(count_r);
          end
        end
        ST_PULSE1: begin
          if (!bus.enable) begin
            state_nx_s = ST_IDLE;
            count_nx_s = 16'd0;
          end else if (count_r == P1_LAST) begin
            state_nx_s = ST_GAP;
            count_nx_s = 16'd0;
          end else begin
            count_nx_s = sat_inc(count_r);
          end
        end
        ST_GAP: begin
          if (!bus.enable) begin
            state_nx_s = ST_IDLE;
            count_nx_s = 16'd0;
          end else if (count_r == GAP_LAST) begin
            state_nx_s = ST_PULSE2;
            count_nx_s = 16'd0;
          end else begin
            count_nx_s = sat_inc(count_r);
          end
        end
        ST_PULSE2: begin
          if (!bus.enable) begin
            state_nx_s = ST_IDLE;
            count_nx_s = 16'd0;
          end else if (count_r == P2_LAST) begin
            state_nx_s = ST_DONE;
            count_nx_s = 16'd0;
          end else begin
            count_nx_s = sat_inc(count_r);
          end
        end
        ST_DONE: begin
          if (!bus.enable) begin
            state_nx_s = ST_IDLE;
          end else begin
            state_nx_s = ST_DONE;
          end
          count_nx_s = 16'd0;
        end
        ST_FAULT: begin
          if (!tem_s && !bus.enable) begin
            state_nx_s = ST_IDLE;
          end else begin
            state_nx_s = ST_FAULT;
          end
          count_nx_s = 16'd0;
        end
        default: begin
          state_nx_s = ST_IDLE;
          count_nx_s = 16'd0;
        end
      endcase
    end
  end

  // Gate decode from the next state so the registered outputs line up with the state.
  always_comb begin
    k1_nx_s = 1'b0;
    k2_nx_s = 1'b0;
    if ((state_nx_s == ST_PULSE1) || (state_nx_s == ST_PULSE2)) begin
      k1_nx_s = 1'b1;
    end else begin
      k1_nx_s = 1'b0;
    end
    if ((state_nx_s == ST_GAP) && in_k2_window(count_nx_s) && !k1_nx_s) begin
      k2_nx_s = 1'b1;
    end else begin
      k2_nx_s = 1'b0;
    end
  end

  // Gate output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      k1_r <= 1'b0;
      k2_r <= 1'b0;
    end else begin
      k1_r <= k1_nx_s;
      k2_r <= k2_nx_s;
    end
  end

  assign bus.K1 = k1_r;
  assign bus.K2 = k2_r;

endmodule

// Interlock checker: K1/K2 mutually exclusive with a minimum both-low gap on every handover.
module double_pulse_driver_chk #(
  parameter int unsigned DEAD_CYC = 20
) (
  input logic clk,
  input logic rst,
  input logic K1,
  input logic K2
);

  localparam logic [15:0] DEAD_W = 16'(DEAD_CYC);

  logic [15:0] k1_low_r;
  logic [15:0] k2_low_r;
  logic        k1_prev_r;
  logic        k2_prev_r;

  // Run lengths of consecutive low cycles on each gate, saturating.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      k1_low_r  <= 16'hFFFF;
      k2_low_r  <= 16'hFFFF;
      k1_prev_r <= 1'b0;
      k2_prev_r <= 1'b0;
    end else begin
      k1_low_r  <= K1 ? 16'd0 : ((k1_low_r == 16'hFFFF) ? k1_low_r : k1_low_r + 16'd1);
      k2_low_r  <= K2 ? 16'd0 : ((k2_low_r == 16'hFFFF) ? k2_low_r : k2_low_r + 16'd1);
      k1_prev_r <= K1;
      k2_prev_r <= K2;
    end
  end

  a_exclusive: assert property (@(posedge clk) disable iff (rst) !(K1 && K2));
  a_dead_k2_rise: assert property (@(posedge clk) disable iff (rst)
    (K2 && !k2_prev_r) |-> (k1_low_r >= DEAD_W));
  a_dead_k1_rise: assert property (@(posedge clk) disable iff (rst)
    (K1 && !k1_prev_r) |-> (k2_low_r >= DEAD_W));

endmodule

// File: tb/tb_double_pulse_driver.sv
// Directed bench for double_pulse_driver at default timing (ARM 4000, P1 400, GAP 200, P2 200, DEAD 20).
module tb_double_pulse_driver;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  double_pulse_driver_if bus ();

  double_pulse_driver dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  double_pulse_driver_chk #(.DEAD_CYC(20)) u_chk (
    .clk (clk),
    .rst (rst),
    .K1  (bus.K1),
    .K2  (bus.K2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Steps negedges until K1 is seen high; lat is the step count, or -1 if the budget runs out.
  task automatic wait_k1(input int budget, output int lat);
    lat = -1;
    for (int i = 1; i <= budget; i++) begin
      @(negedge clk);
      if (bus.K1 === 1'b1) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.enable = 1'b0;
    bus.TEM = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if (bus.K1 !== 1'b0) begin bad++; $display("FAIL reset_k1: got %b want 0", bus.K1); end
    total++;
    if (bus.K2 !== 1'b0) begin bad++; $display("FAIL reset_k2: got %b want 0", bus.K2); end
    rst = 1'b0;
    repeat (5) @(negedge clk);
    total++;
    if (bus.K1 !== 1'b0) begin bad++; $display("FAIL idle_k1: got %b want 0", bus.K1); end
    total++;
    if (bus.K2 !== 1'b0) begin bad++; $display("FAIL idle_k2: got %b want 0", bus.K2); end
  endtask

  task automatic test_nominal();
    int lat, first_bad, k1_hi, k2_hi, stray;
    logic exp_k1, exp_k2, got_k1, got_k2;
    bus.enable = 1'b1;
    wait_k1(5000, lat);
    total++;
    if (lat !== 4001) begin bad++; $display("FAIL nominal_latency: got %0d want 4001", lat); end
    first_bad = -1; k1_hi = 0; k2_hi = 0; exp_k1 = 1'b0; exp_k2 = 1'b0; got_k1 = 1'b0; got_k2 = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      if (i > 0) @(negedge clk);
      if (bus.K1 === 1'b1) k1_hi++;
      if (bus.K2 === 1'b1) k2_hi++;
      if (first_bad < 0 &&
          ((bus.K1 !== ((i < 400) || (i >= 600 && i < 800))) || (bus.K2 !== (i >= 420 && i < 580)))) begin
        first_bad = i;
        got_k1 = bus.K1; got_k2 = bus.K2;
        exp_k1 = (i < 400) || (i >= 600 && i < 800);
        exp_k2 = (i >= 420 && i < 580);
      end
    end
    total++;
    if (first_bad != -1) begin
      bad++;
      $display("FAIL nominal_trace: cycle %0d got K1=%b K2=%b want K1=%b K2=%b",
               first_bad, got_k1, got_k2, exp_k1, exp_k2);
    end
    total++;
    if (k1_hi != 600) begin bad++; $display("FAIL nominal_k1_width: got %0d want 600", k1_hi); end
    total++;
    if (k2_hi != 160) begin bad++; $display("FAIL nominal_k2_width: got %0d want 160", k2_hi); end
    stray = 0;
    repeat (500) begin
      @(negedge clk);
      if (bus.K1 !== 1'b0 || bus.K2 !== 1'b0) stray++;
    end
    total++;
    if (stray != 0) begin bad++; $display("FAIL nominal_no_retrigger: got %0d active cycles want 0", stray); end
  endtask

  task automatic test_back_to_back();
    int lat, first_bad, k1_hi, k2_hi;
    bus.enable = 1'b0;
    repeat (2) @(negedge clk);
    bus.enable = 1'b1;
    wait_k1(5000, lat);
    total++;
    if (lat !== 4001) begin bad++; $display("FAIL retrigger_latency: got %0d want 4001", lat); end
    first_bad = -1; k1_hi = 0; k2_hi = 0;
    for (int i = 0; i < 1000; i++) begin
      if (i > 0) @(negedge clk);
      if (bus.K1 === 1'b1) k1_hi++;
      if (bus.K2 === 1'b1) k2_hi++;
      if (first_bad < 0 &&
          ((bus.K1 !== ((i < 400) || (i >= 600 && i < 800))) || (bus.K2 !== (i >= 420 && i < 580))))
        first_bad = i;
    end
    total++;
    if (first_bad != -1) begin bad++; $display("FAIL retrigger_trace: first bad cycle %0d want none", first_bad); end
    total++;
    if (k1_hi != 600) begin bad++; $display("FAIL retrigger_k1_width: got %0d want 600", k1_hi); end
    total++;
    if (k2_hi != 160) begin bad++; $display("FAIL retrigger_k2_width: got %0d want 160", k2_hi); end
  endtask

  task automatic test_debounce();
    int lat, stray;
    bus.enable = 1'b0;
    repeat (3) @(negedge clk);
    bus.enable = 1'b1;
    stray = 0;
    repeat (3999) begin
      @(negedge clk);
      if (bus.K1 !== 1'b0 || bus.K2 !== 1'b0) stray++;
    end
    bus.enable = 1'b0;
    @(negedge clk);
    if (bus.K1 !== 1'b0 || bus.K2 !== 1'b0) stray++;
    total++;
    if (stray != 0) begin bad++; $display("FAIL debounce_quiet: got %0d active cycles want 0", stray); end
    bus.enable = 1'b1;
    wait_k1(5000, lat);
    total++;
    if (lat !== 4001) begin bad++; $display("FAIL debounce_latency: got %0d want 4001", lat); end
  endtask

  task automatic test_abort();
    int lat;
    bus.enable = 1'b0;
    repeat (3) @(negedge clk);
    bus.enable = 1'b1;
    wait_k1(5000, lat);
    repeat (100) @(negedge clk);
    total++;
    if (bus.K1 !== 1'b1) begin bad++; $display("FAIL abort_pre_k1: got %b want 1", bus.K1); end
    bus.enable = 1'b0;
    @(negedge clk);
    total++;
    if (bus.K1 !== 1'b0) begin bad++; $display("FAIL abort_k1: got %b want 0", bus.K1); end
    total++;
    if (bus.K2 !== 1'b0) begin bad++; $display("FAIL abort_k2: got %b want 0", bus.K2); end
    repeat (2) @(negedge clk);
    bus.enable = 1'b1;
    wait_k1(5000, lat);
    total++;
    if (lat !== 4001) begin bad++; $display("FAIL abort_rearm_latency: got %0d want 4001", lat); end
  endtask

  task automatic test_overtemp();
    int lat, stray, w;
    bus.enable = 1'b0;
    repeat (3) @(negedge clk);
    bus.enable = 1'b1;
    wait_k1(5000, lat);
    repeat (450) @(negedge clk);
    total++;
    if (bus.K2 !== 1'b1 || bus.K1 !== 1'b0) begin
      bad++; $display("FAIL tem_pre_gap: got K1=%b K2=%b want K1=0 K2=1", bus.K1, bus.K2);
    end
    bus.TEM = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if (bus.K2 !== 1'b1) begin bad++; $display("FAIL tem_sync_latency: got K2=%b want 1", bus.K2); end
    @(negedge clk);
    total++;
    if (bus.K1 !== 1'b0 || bus.K2 !== 1'b0) begin
      bad++; $display("FAIL tem_shutdown: got K1=%b K2=%b want 0 0", bus.K1, bus.K2);
    end
    bus.TEM = 1'b0;
    stray = 0;
    repeat (4200) begin
      @(negedge clk);
      if (bus.K1 !== 1'b0 || bus.K2 !== 1'b0) stray++;
    end
    total++;
    if (stray != 0) begin bad++; $display("FAIL tem_no_restart: got %0d active cycles want 0", stray); end
    bus.enable = 1'b0;
    repeat (3) @(negedge clk);
    bus.enable = 1'b1;
    wait_k1(5000, lat);
    total++;
    if (lat !== 4001) begin bad++; $display("FAIL tem_recover_latency: got %0d want 4001", lat); end
    w = 0;
    for (int i = 0; i < 500; i++) begin
      if (bus.K1 !== 1'b1) break;
      w++;
      @(negedge clk);
    end
    total++;
    if (w != 400) begin bad++; $display("FAIL tem_recover_p1: got %0d want 400", w); end
  endtask

  task automatic test_async_reset();
    int lat, stray;
    bus.enable = 1'b0;
    repeat (3) @(negedge clk);
    bus.enable = 1'b1;
    wait_k1(5000, lat);
    repeat (650) @(negedge clk);
    total++;
    if (bus.K1 !== 1'b1) begin bad++; $display("FAIL areset_pre_k1: got %b want 1", bus.K1); end
    bus.enable = 1'b0;
    #1 rst = 1'b1;
    #1;
    total++;
    if (bus.K1 !== 1'b0) begin bad++; $display("FAIL areset_k1_immediate: got %b want 0", bus.K1); end
    total++;
    if (bus.K2 !== 1'b0) begin bad++; $display("FAIL areset_k2_immediate: got %b want 0", bus.K2); end
    #4 rst = 1'b0;
    stray = 0;
    repeat (50) begin
      @(negedge clk);
      if (bus.K1 !== 1'b0 || bus.K2 !== 1'b0) stray++;
    end
    total++;
    if (stray != 0) begin bad++; $display("FAIL areset_idle: got %0d active cycles want 0", stray); end
    bus.enable = 1'b1;
    wait_k1(5000, lat);
    total++;
    if (lat !== 4001) begin bad++; $display("FAIL areset_rearm_latency: got %0d want 4001", lat); end
  endtask

  initial begin
    total = 0;
    bad = 0;
    test_reset();
    test_nominal();
    test_back_to_back();
    test_debounce();
    test_abort();
    test_overtemp();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/double_pulse_driver.md
Name: double_pulse_driver

Overview:
- Single-shot double-pulse gate-drive sequencer for power-switch characterisation. It drives two complementary gate outputs, K1 (main switch) and K2 (freewheel/complement).
- Armed by the upstream voltage-window qualifier (enable = bus voltage in the valid range). Inhibited by the TEM over-temperature input.
- One instance per switch leg, with all instances on the shared system clock (40 MHz, 25 ns/cycle).

Parameters:
- ARM_CYC, 4000, cycles enable must stay continuously high before the sequence starts (100 us debounce).
- P1_CYC, 400, first K1 pulse width in cycles (10 us).
- GAP_CYC, 200, K1 off-time between pulses in cycles (5 us); must exceed 2*DEAD_CYC.
- P2_CYC, 200, second K1 pulse width in cycles (5 us).
- DEAD_CYC, 20, dead time between K1 and K2 edges in cycles (500 ns).
- All parameters are 1..65535; counters are 16 bits.

Ports:
- clk, in, 1, system clock, rising-edge.
- rst, in, 1, asynchronous active-high reset.
- enable, in, 1, sequence request, synchronous to clk.
- TEM, in, 1, over-temperature fault, active-high, asynchronous; passes through a 2-FF synchroniser internally.
- K1, out, 1, main gate drive, registered.
- K2, out, 1, complementary gate drive, registered.

Behaviour:
- Reset (rst=1, any time, mid-sequence included):
  - K1=0, K2=0, state IDLE, counters 0, synchroniser flops 0.
  - Effect is immediate (asynchronous).
- Fault signal: tem_s is TEM after 2 flops (2-cycle latency).
- States: IDLE, ARM, PULSE1, GAP, PULSE2, DONE, FAULT.
- IDLE:
  - K1=K2=0.
  - enable=1 and tem_s=0 -> ARM, count=0.
- ARM:
  - K1=K2=0; count increments every cycle.
  - enable=0 -> IDLE.
  - count reaches ARM_CYC-1 -> PULSE1, count=0.
- PULSE1:
  - K1=1 for exactly P1_CYC cycles; K2=0.
  - Then -> GAP, count=0.
- GAP:
  - K1=0 for exactly GAP_CYC cycles.
  - K2=1 only at gap cycle indices DEAD_CYC through GAP_CYC-DEAD_CYC-1 inclusive; K2=0 elsewhere.
  - Then -> PULSE2, count=0.
- PULSE2:
  - K1=1 for exactly P2_CYC cycles; K2=0.
  - Then -> DONE.
- DONE:
  - K1=K2=0.
  - Stays until enable=0, then -> IDLE.
  - Exactly one double pulse per enable assertion; holding enable high never retriggers.
- Abort: in ARM, PULSE1, GAP or PULSE2, enable=0 forces K1=K2=0 on the next clock edge and -> IDLE.
- FAULT:
  - Entered from any non-reset state when tem_s=1, with K1=K2=0 on the next edge.
  - Fault has priority over all other transitions, including a simultaneous enable edge or sequence completion.
  - Exit -> IDLE only when tem_s=0 and enable=0 together; no auto-restart.
- Output timing: K1 and K2 are flop outputs with no combinational path from any input. The first K1 high cycle is the cycle after ARM completes.
- Interlock:
  - K1 and K2 are never 1 in the same cycle.
  - At least DEAD_CYC cycles of both-low separate every K1 fall from a K2 rise, and every K2 fall from a K1 rise.
  - The interlock is enforced by construction and checked by assertion.
- Counters: count saturates and never wraps; every state compares against its own parameter minus 1.

Test Plan:
- Nominal sequence: reset, TEM=0, raise enable and hold it. Required response, counted from the first K1 high cycle:
  - K1 high 400 cycles, then low 200, then high 200, then low forever.
  - K2 high for 160 cycles, starting 20 cycles after the first K1 fall and ending 20 cycles before the second K1 rise.
  - No second sequence while enable stays high.
- Debounce: enable high 3999 cycles, low 1 cycle, high again. Required: no K1 activity until 4000 consecutive high cycles have completed after the re-raise.
- Mid-pulse abort: drop enable during PULSE1 at count 100. Required: K1=0 on the next edge, K2 stays 0, state IDLE; re-raising enable restarts the full ARM period.
- Over-temperature: assert TEM during GAP while K2=1. Required:
  - K1=K2=0 within 3 cycles of the TEM edge (2 synchroniser cycles + 1 output register).
  - TEM=0 with enable=1 keeps outputs low; after enable goes 0 and then 1 again, a full sequence runs.
- Asynchronous reset: pulse rst for half a cycle during PULSE2. Required: K1 drops with no clock edge, and after rst is released the block sits in IDLE.
- Retrigger and interlock: toggle enable 0->1 after DONE. Required:
  - A second identical double pulse follows ARM_CYC cycles later.
  - The assertion that K1 and K2 are never both high, with at least 20 cycles of dead time, holds across all scenarios.
